// File: rtl/dw_data_qsync_arb_pkg.sv
// Shared types and constants for the quasi-sync send arbiter.
// State encoding, legal parameter ranges and a constant-function clog2.
package dw_data_qsync_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_MIN   = 2;
    localparam int NUM_REQ_MAX   = 16;
    localparam int CLK_RATIO_MIN = 2;
    localparam int CLK_RATIO_MAX = 1024;

    // Returns at least 1 so single-entry ranges still get a usable vector.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dw_rr_arb.sv
// Combinational round-robin pick: the first set request after last, wrapping.
// Zero latency and no backpressure; the caller decides when the pick is used.
module dw_rr_arb
    import dw_data_qsync_arb_pkg::*;
#(
    parameter int num_req   = 4,
    parameter int idx_width = 2
) (
    input  logic [num_req-1:0]   req,
    input  logic [idx_width-1:0] last,
    output logic [num_req-1:0]   gnt,
    output logic [idx_width-1:0] idx,
    output logic                 any
);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        // Start one past last so the previous winner is searched last.
        for (int k = 1; k <= num_req; k++) begin
            cand = (int'(last) + k) % num_req;
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = idx_width'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dw_data_qsync_hl_send_arb.sv
// Shares one quasi-sync channel among num_req requesters with round-robin grants.
// Request to send/grant is 1 cycle; after each send, requests are ignored for clk_ratio cycles.
module dw_data_qsync_hl_send_arb
    import dw_data_qsync_arb_pkg::*;
#(
    parameter int width     = 8,
    parameter int num_req   = 4,
    parameter int clk_ratio = 2,
    parameter int cnt_width = 16
) (
    input  logic                     clk_s,
    input  logic                     rst_s_n,
    input  logic                     init_s_n,
    input  logic [num_req-1:0]       req_s,
    input  logic [num_req*width-1:0] data_req_s,
    output logic [num_req-1:0]       gnt_s,
    output logic                     send_s,
    output logic [width-1:0]         data_s,
    output logic                     busy_s,
    output logic [cnt_width-1:0]     sent_cnt_s
);

    localparam int IDX_W = clog2(num_req);
    localparam int GAP_W = clog2(clk_ratio + 1);

    if (num_req < NUM_REQ_MIN || num_req > NUM_REQ_MAX) begin : g_bad_num_req
        $error("dw_data_qsync_hl_send_arb: num_req must be in 2..16");
    end
    if (clk_ratio < CLK_RATIO_MIN || clk_ratio > CLK_RATIO_MAX) begin : g_bad_clk_ratio
        $error("dw_data_qsync_hl_send_arb: clk_ratio must be in 2..1024");
    end

    arb_state_t         state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [IDX_W-1:0]   last;

    logic [num_req-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [width-1:0]   pick_dat;

    dw_rr_arb #(
        .num_req   (num_req),
        .idx_width (IDX_W)
    ) u_rr_arb (
        .req  (req_s),
        .last (last),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        pick_dat = data_req_s[int'(pick_idx)*width +: width];
    end

    always_ff @(posedge clk_s) begin
        if (!rst_s_n || !init_s_n) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            last       <= IDX_W'(num_req - 1);
            gnt_s      <= '0;
            send_s     <= 1'b0;
            data_s     <= '0;
            busy_s     <= 1'b0;
            sent_cnt_s <= '0;
        end else begin
            send_s <= 1'b0;
            gnt_s  <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        send_s     <= 1'b1;
                        gnt_s      <= pick_gnt;
                        data_s     <= pick_dat;
                        last       <= pick_idx;
                        sent_cnt_s <= sent_cnt_s + cnt_width'(1);
                        gap_cnt    <= GAP_W'(clk_ratio);
                        busy_s     <= 1'b1;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    // Leaving at count 1 gives clk_ratio low cycles between sends.
                    if (gap_cnt <= GAP_W'(1)) begin
                        gap_cnt <= '0;
                        busy_s  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dw_data_qsync_hl_send_arb.sv
// Scoreboard bench for the round-robin quasi-sync send arbiter.
// Expected sends are queued by the stimulus and popped by a negedge monitor.
module tb_dw_data_qsync_hl_send_arb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, init_n, rst1_n;
    logic [3:0]  req, req1;
    logic [31:0] dreq;

    logic [3:0]  gnt0, gnt1;
    logic        send0, send1, busy0, busy1;
    logic [7:0]  data0, data1;
    logic [3:0]  cnt0;
    logic [15:0] cnt1;

    dw_data_qsync_hl_send_arb #(
        .width(8), .num_req(4), .clk_ratio(2), .cnt_width(4)
    ) u0 (
        .clk_s(clk), .rst_s_n(rst_n), .init_s_n(init_n), .req_s(req),
        .data_req_s(dreq), .gnt_s(gnt0), .send_s(send0), .data_s(data0),
        .busy_s(busy0), .sent_cnt_s(cnt0)
    );

    dw_data_qsync_hl_send_arb #(
        .width(8), .num_req(4), .clk_ratio(5), .cnt_width(16)
    ) u1 (
        .clk_s(clk), .rst_s_n(rst1_n), .init_s_n(1'b1), .req_s(req1),
        .data_req_s(dreq), .gnt_s(gnt1), .send_s(send1), .data_s(data1),
        .busy_s(busy1), .sent_cnt_s(cnt1)
    );

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] dat;
        logic [3:0] cnt;
    } exp_t;

    exp_t       q[$];
    exp_t       e_m;
    logic [7:0] dv[4];

    int  n_chk = 0, n_fail = 0;
    int  cyc = 0;
    int  n_send = 0, last_send = -1;
    bit  sat_mode = 1'b0;
    bit  mon1_en = 1'b0;
    int  sends1 = 0, last1 = -1;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int g, input int c);
        exp_t e;
        e.gnt = 4'(1 << g);
        e.dat = dv[g];
        e.cnt = 4'(c);
        q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_sends(input int target, input int budget);
        for (int i = 0; i < budget && n_send < target; i++) tick();
        if (n_send < target) chk("send_timeout", n_send, target);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Main channel monitor: every send must match the head of the queue.
    always @(negedge clk) begin
        if (send0) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_send: got gnt %b expected no send", gnt0);
            end else begin
                e_m = q.pop_front();
                chk("grant", gnt0, e_m.gnt);
                chk("data", data0, e_m.dat);
                chk("sent_cnt", cnt0, e_m.cnt);
            end
            if (sat_mode && last_send >= 0) chk("sat_spacing", cyc - last_send, 3);
            last_send = cyc;
            n_send++;
        end else begin
            chk("gnt_without_send", gnt0, 0);
        end
    end

    // Slow-ratio monitor: exact spacing of 6 and busy for the first 5 cycles of each window.
    always @(negedge clk) begin
        if (mon1_en) begin
            if (send1) begin
                if (last1 >= 0) chk("ratio5_spacing", cyc - last1, 6);
                chk("ratio5_gnt", (gnt1 == 4'b0001 || gnt1 == 4'b0010), 1);
                chk("ratio5_data", data1, gnt1[0] ? dv[0] : dv[1]);
                chk("ratio5_cnt", cnt1, sends1 + 1);
                last1 = cyc;
                sends1++;
            end
            chk("ratio5_busy", busy1, (last1 >= 0) && (cyc - last1 <= 4));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int seq3[3];

    initial begin
        dv[0] = 8'h10; dv[1] = 8'h21; dv[2] = 8'hA5; dv[3] = 8'h3C;
        dreq   = {dv[3], dv[2], dv[1], dv[0]};
        rst_n  = 1'b0;
        init_n = 1'b1;
        rst1_n = 1'b0;
        req1   = 4'b0000;

        // Reset holds every output low even with all requests asserted.
        req = 4'b1111;
        repeat (3) begin
            tick();
            chk("rst_send", send0, 0);
            chk("rst_gnt", gnt0, 0);
            chk("rst_busy", busy0, 0);
            chk("rst_data", data0, 0);
            chk("rst_cnt", cnt0, 0);
        end

        // Saturation: rotation 0,1,2,3 from requester 0, one send every 3 cycles.
        for (int k = 0; k < 12; k++) push(k % 4, k + 1);
        sat_mode  = 1'b1;
        last_send = -1;
        rst_n     = 1'b1;
        wait_sends(12, 100);
        req      = 4'b0000;
        sat_mode = 1'b0;
        repeat (5) tick();
        chk("sat_final_cnt", cnt0, 12);
        chk("sat_queue_empty", q.size(), 0);

        // Single request, one-cycle latency.
        do_reset();
        req = 4'b0100;
        push(2, 1);
        tick();
        chk("lat_send", send0, 1);
        chk("lat_gnt", gnt0, 4'b0100);
        chk("lat_busy", busy0, 1);
        req = 4'b0000;
        repeat (5) tick();

        // Init during the gap aborts it; the pending request wins right after.
        do_reset();
        req = 4'b0001;
        push(0, 1);
        tick();
        chk("pre_init_send", send0, 1);
        req    = 4'b1000;
        init_n = 1'b0;
        tick();
        init_n = 1'b1;
        chk("init_busy", busy0, 0);
        chk("init_cnt", cnt0, 0);
        chk("init_send", send0, 0);
        push(3, 1);
        tick();
        chk("init_regrant", send0, 1);
        req = 4'b0000;
        repeat (5) tick();

        // Wrap at 16 and withdrawal of requester 2 before its turn.
        do_reset();
        req = 4'b1111;
        push(0, 1);
        tick();
        chk("wrap_first_send", send0, 1);
        req = 4'b1011;
        seq3[0] = 1; seq3[1] = 3; seq3[2] = 0;
        for (int k = 1; k < 17; k++) push(seq3[(k - 1) % 3], (k + 1) % 16);
        wait_sends(n_send + 16, 200);
        req = 4'b0000;
        repeat (5) tick();
        chk("wrap_cnt", cnt0, 1);
        chk("wrap_queue_empty", q.size(), 0);

        // clk_ratio=5 channel: requester 1 steady, requester 0 toggling every cycle.
        rst1_n  = 1'b1;
        mon1_en = 1'b1;
        req1    = 4'b0010;
        for (int i = 0; i < 40; i++) begin
            tick();
            req1[0] = ~req1[0];
        end
        mon1_en = 1'b0;
        req1    = 4'b0000;
        chk("ratio5_send_count", sends1, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
